// File: rtl/div_iter_if.sv
// Handshake/result bundle between the divider datapath (slave) and the side
// that drives start/operands and the FSM commands (master).
interface div_iter_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             do_iter;
  logic             ready;
  logic             zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             valid;
  logic             div_err;
  logic [WIDTH-1:0] iter_cnt;

  modport slave (
    input  start, dividend, divisor, do_iter, ready,
    output zero, quotient, remainder, valid, div_err, iter_cnt
  );

  modport master (
    output start, dividend, divisor, do_iter, ready,
    input  zero, quotient, remainder, valid, div_err, iter_cnt
  );
endinterface

// File: rtl/div_iter_dp.sv
// Repeated-subtraction divider: one-hot control FSM plus the datapath it drives.
// Define DIV_ITER_DP_CNT_EN to add the subtraction counter behind iter_cnt.

module div_iter_fsm (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_zero,
  output logic o_do_iter,
  output logic o_ready
);
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_CHK  = 5'b00010,
    S_ITER = 5'b00100,
    S_LAST = 5'b01000,
    S_DONE = 5'b10000
  } state_t;

  state_t r_state;
  logic   r_do_iter;
  logic   r_ready;

  // S_CHK catches the no-subtraction case straight away; once subtracting, the
  // loop spends one settle cycle in S_LAST before signalling done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_do_iter <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_do_iter <= 1'b0;
      r_ready   <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state   <= S_CHK;
          r_do_iter <= 1'b1;
        end
        S_CHK: if (i_zero) begin
          r_state <= S_DONE;
          r_ready <= 1'b1;
        end else begin
          r_state   <= S_ITER;
          r_do_iter <= 1'b1;
        end
        S_ITER: if (i_zero) begin
          r_state <= S_LAST;
        end else begin
          r_do_iter <= 1'b1;
        end
        S_LAST: begin
          r_state <= S_DONE;
          r_ready <= 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_do_iter = r_do_iter;
  assign o_ready   = r_ready;
endmodule

module div_iter_dp #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  div_iter_if.slave   bus
);
  logic             r_busy;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_valid;
  logic             r_div_err;
  logic             w_zero;
  logic             w_dvs_zero;
  logic             w_accept;
  logic             w_sub;

  assign w_dvs_zero = (r_dvs == '0);
  assign w_zero     = w_dvs_zero | (r_rem < r_dvs);
  assign w_accept   = bus.start & ~r_busy;
  assign w_sub      = bus.do_iter & ~w_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_valid     <= 1'b0;
      r_div_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        r_rem  <= bus.dividend;
        r_quo  <= '0;
        r_dvs  <= bus.divisor;
        r_busy <= 1'b1;
      end else if (w_sub) begin
        r_rem <= r_rem - r_dvs;
        r_quo <= r_quo + WIDTH'(1);
      end
      // rem still holds the dividend when dvs==0, so only quotient needs forcing
      if (bus.ready) begin
        r_quotient  <= w_dvs_zero ? '1 : r_quo;
        r_remainder <= r_rem;
        r_div_err   <= w_dvs_zero;
        r_valid     <= 1'b1;
        r_busy      <= 1'b0;
      end
    end
  end

`ifdef DIV_ITER_DP_CNT_EN
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_iter_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_iter_cnt <= '0;
    end else begin
      if (w_accept)   r_cnt <= '0;
      else if (w_sub) r_cnt <= r_cnt + WIDTH'(1);
      if (bus.ready)  r_iter_cnt <= r_cnt;
    end
  end

  assign bus.iter_cnt = r_iter_cnt;
`else
  assign bus.iter_cnt = '0;
`endif

  assign bus.zero      = w_zero;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.valid     = r_valid;
  assign bus.div_err   = r_div_err;
endmodule

// File: tb/tb_div_iter_dp.sv
// Directed bench: datapath plus control FSM, edges counted from the start-accept edge.
module tb_div_iter_dp;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef DIV_ITER_DP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  div_iter_if #(.WIDTH(W)) bus ();

  assign rst_n = ~rst;
  always #5 clk = ~clk;

  div_iter_dp #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  div_iter_fsm fsm (
    .clk(clk), .rst_n(rst_n), .i_start(bus.start), .i_zero(bus.zero),
    .o_do_iter(bus.do_iter), .o_ready(bus.ready)
  );

  // Pulse start for one accept edge (edge 0), then count edges until valid.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int vedge, output int npulse);
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    vedge  = -1;
    npulse = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (bus.valid) begin
        npulse++;
        if (vedge < 0) vedge = k;
      end
      if (vedge >= 0 && k >= vedge + 3) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.quotient !== 8'd0) begin n_fail++; $display("FAIL reset_quotient: got %0d exp 0", bus.quotient); end
    n_tests++; if (bus.remainder !== 8'd0) begin n_fail++; $display("FAIL reset_remainder: got %0d exp 0", bus.remainder); end
    n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", bus.valid); end
    n_tests++; if (bus.div_err !== 1'b0) begin n_fail++; $display("FAIL reset_div_err: got %b exp 0", bus.div_err); end
    n_tests++; if (bus.iter_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_iter_cnt: got %0d exp 0", bus.iter_cnt); end
    n_tests++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b exp 1", bus.zero); end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    int ve, np;
    logic [W-1:0] exp_cnt;
    exp_cnt = CNT_EN ? 8'd3 : 8'd0;
    do_op(8'd13, 8'd4, ve, np);
    n_tests++; if (ve !== 6) begin n_fail++; $display("FAIL normal_latency: got edge %0d exp 6", ve); end
    n_tests++; if (np !== 1) begin n_fail++; $display("FAIL normal_pulses: got %0d exp 1", np); end
    n_tests++; if (bus.quotient !== 8'd3) begin n_fail++; $display("FAIL normal_quotient: got %0d exp 3", bus.quotient); end
    n_tests++; if (bus.remainder !== 8'd1) begin n_fail++; $display("FAIL normal_remainder: got %0d exp 1", bus.remainder); end
    n_tests++; if (bus.div_err !== 1'b0) begin n_fail++; $display("FAIL normal_div_err: got %b exp 0", bus.div_err); end
    n_tests++; if (bus.iter_cnt !== exp_cnt) begin n_fail++; $display("FAIL normal_iter_cnt: got %0d exp %0d", bus.iter_cnt, exp_cnt); end
  endtask

  task automatic test_small();
    int ve, np;
    do_op(8'd5, 8'd7, ve, np);
    n_tests++; if (ve !== 2) begin n_fail++; $display("FAIL small_latency: got edge %0d exp 2", ve); end
    n_tests++; if (bus.quotient !== 8'd0) begin n_fail++; $display("FAIL small_quotient: got %0d exp 0", bus.quotient); end
    n_tests++; if (bus.remainder !== 8'd5) begin n_fail++; $display("FAIL small_remainder: got %0d exp 5", bus.remainder); end
    n_tests++; if (bus.div_err !== 1'b0) begin n_fail++; $display("FAIL small_div_err: got %b exp 0", bus.div_err); end
  endtask

  task automatic test_long();
    int ve, np;
    logic [W-1:0] exp_cnt;
    exp_cnt = CNT_EN ? 8'd255 : 8'd0;
    do_op(8'd255, 8'd1, ve, np);
    n_tests++; if (ve !== 258) begin n_fail++; $display("FAIL long_latency: got edge %0d exp 258", ve); end
    n_tests++; if (bus.quotient !== 8'd255) begin n_fail++; $display("FAIL long_quotient: got %0d exp 255", bus.quotient); end
    n_tests++; if (bus.remainder !== 8'd0) begin n_fail++; $display("FAIL long_remainder: got %0d exp 0", bus.remainder); end
    n_tests++; if (bus.iter_cnt !== exp_cnt) begin n_fail++; $display("FAIL long_iter_cnt: got %0d exp %0d", bus.iter_cnt, exp_cnt); end
  endtask

  task automatic test_div_zero();
    int ve, np;
    do_op(8'd9, 8'd0, ve, np);
    n_tests++; if (ve !== 2) begin n_fail++; $display("FAIL divzero_latency: got edge %0d exp 2", ve); end
    n_tests++; if (bus.quotient !== 8'hFF) begin n_fail++; $display("FAIL divzero_quotient: got %0h exp ff", bus.quotient); end
    n_tests++; if (bus.remainder !== 8'd9) begin n_fail++; $display("FAIL divzero_remainder: got %0d exp 9", bus.remainder); end
    n_tests++; if (bus.div_err !== 1'b1) begin n_fail++; $display("FAIL divzero_div_err: got %b exp 1", bus.div_err); end
  endtask

  // Second start sampled at edge 2 (mid-run) and edge 6 (the ready cycle).
  task automatic test_start_busy();
    int ve, np;
    @(negedge clk);
    bus.dividend = 8'd13;
    bus.divisor  = 8'd4;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ve = -1;
    np = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (bus.valid) begin
        np++;
        if (ve < 0) ve = k;
      end
      if (k == 1 || k == 5) begin
        bus.dividend = 8'd100;
        bus.divisor  = 8'd10;
        bus.start    = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    n_tests++; if (ve !== 6) begin n_fail++; $display("FAIL busy_latency: got edge %0d exp 6", ve); end
    n_tests++; if (np !== 1) begin n_fail++; $display("FAIL busy_pulses: got %0d exp 1", np); end
    n_tests++; if (bus.quotient !== 8'd3) begin n_fail++; $display("FAIL busy_quotient: got %0d exp 3", bus.quotient); end
    n_tests++; if (bus.remainder !== 8'd1) begin n_fail++; $display("FAIL busy_remainder: got %0d exp 1", bus.remainder); end
  endtask

  task automatic test_reset_mid();
    int ve, np;
    @(negedge clk);
    bus.dividend = 8'd255;
    bus.divisor  = 8'd1;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (bus.quotient !== 8'd0) begin n_fail++; $display("FAIL midrst_quotient: got %0d exp 0", bus.quotient); end
    n_tests++; if (bus.remainder !== 8'd0) begin n_fail++; $display("FAIL midrst_remainder: got %0d exp 0", bus.remainder); end
    n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b exp 0", bus.valid); end
    n_tests++; if (bus.iter_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_iter_cnt: got %0d exp 0", bus.iter_cnt); end
    np = 0;
    for (int k = 0; k < 270; k++) begin
      @(posedge clk); #1;
      if (bus.valid) np++;
    end
    n_tests++; if (np !== 0) begin n_fail++; $display("FAIL midrst_no_valid: got %0d pulses exp 0", np); end
    do_op(8'd20, 8'd6, ve, np);
    n_tests++; if (ve !== 6) begin n_fail++; $display("FAIL after_rst_latency: got edge %0d exp 6", ve); end
    n_tests++; if (bus.quotient !== 8'd3) begin n_fail++; $display("FAIL after_rst_quotient: got %0d exp 3", bus.quotient); end
    n_tests++; if (bus.remainder !== 8'd2) begin n_fail++; $display("FAIL after_rst_remainder: got %0d exp 2", bus.remainder); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_small();
    test_long();
    test_div_zero();
    test_start_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
